div: RTL and testbench

DIV -- requirements
Module: div

---
 rtl/div_if.sv | 21 ++
 rtl/div.sv | 129 ++++++++++++
 tb/tb_div.sv | 128 ++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Request/response bundle between the EX stage and the divider.
// The EX stage drives the master side; the divider sits on the slave side.
interface div_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div.sv
// Multi-cycle 32-bit restoring divider (signed and unsigned).
// Operands are reduced to magnitudes on capture, 32 shift-subtract steps
// produce quotient and remainder, and signs are restored on the way out.
// result_o is {remainder, quotient}; both outputs come straight from flops.
module div (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t      state, state_n;
    logic [5:0]  cnt, cnt_n;
    logic [31:0] dvs, dvs_n;
    logic [31:0] quo, quo_n;
    logic [31:0] rem, rem_n;
    logic        neg_quo, neg_quo_n;
    logic        neg_rem, neg_rem_n;
    logic [63:0] fin, fin_n;
    logic [63:0] result_q, result_n;
    logic        ready_q, ready_n;

    // 33-bit partial remainder for the current step: old remainder shifted
    // left with the next dividend bit brought in from the top of quo.
    logic [32:0] shifted;
    logic        fits;

    assign shifted = {rem, quo[31]};
    assign fits    = (shifted >= {1'b0, dvs});

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;

    // State and datapath registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= 6'd0;
            dvs      <= 32'h0;
            quo      <= 32'h0;
            rem      <= 32'h0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            fin      <= 64'h0;
            result_q <= 64'h0;
            ready_q  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            dvs      <= dvs_n;
            quo      <= quo_n;
            rem      <= rem_n;
            neg_quo  <= neg_quo_n;
            neg_rem  <= neg_rem_n;
            fin      <= fin_n;
            result_q <= result_n;
            ready_q  <= ready_n;
        end
    end

    // Next-state and next-datapath logic. BYZERO dwells two edges (cnt 0,1)
    // so a zero divisor reports ready three edges after acceptance, and the
    // ON state spends one extra edge after the last step applying signs.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        dvs_n     = dvs;
        quo_n     = quo;
        rem_n     = rem;
        neg_quo_n = neg_quo;
        neg_rem_n = neg_rem;
        fin_n     = fin;
        result_n  = 64'h0;
        ready_n   = 1'b0;

        case (state)
            FREE: begin
                if (bus.start_i && !bus.annul_i) begin
                    quo_n     = (bus.signed_div_i && bus.opdata1_i[31]) ? -bus.opdata1_i : bus.opdata1_i;
                    dvs_n     = (bus.signed_div_i && bus.opdata2_i[31]) ? -bus.opdata2_i : bus.opdata2_i;
                    rem_n     = 32'h0;
                    cnt_n     = 6'd0;
                    fin_n     = 64'h0;
                    neg_quo_n = bus.signed_div_i && (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
                    neg_rem_n = bus.signed_div_i && bus.opdata1_i[31];
                    state_n   = (bus.opdata2_i == 32'h0) ? BYZERO : ON;
                end
            end

            BYZERO: begin
                if (cnt == 6'd1) begin
                    fin_n   = 64'h0;
                    cnt_n   = 6'd0;
                    state_n = END;
                end else begin
                    cnt_n = cnt + 6'd1;
                end
            end

            ON: begin
                if (bus.annul_i) begin
                    cnt_n   = 6'd0;
                    state_n = FREE;
                end else if (cnt == 6'd32) begin
                    fin_n   = {(neg_rem ? -rem : rem), (neg_quo ? -quo : quo)};
                    cnt_n   = 6'd0;
                    state_n = END;
                end else begin
                    rem_n = fits ? (shifted[31:0] - dvs) : shifted[31:0];
                    quo_n = {quo[30:0], fits};
                    cnt_n = cnt + 6'd1;
                end
            end

            END: begin
                if (bus.start_i) begin
                    result_n = fin;
                    ready_n  = 1'b1;
                end else begin
                    state_n = FREE;
                end
            end

            default: state_n = FREE;
        endcase
    end

endmodule

// File: tb/tb_div.sv
// Directed testbench for the divider: latency, signed/unsigned results,
// divide by zero, annul, reset mid-operation and corner operands.
module tb_div;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    div_if bus ();

    div dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Present a request at a falling edge; the following rising edge is E0.
    task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        bus.annul_i      = 1'b0;
    endtask

    // Full transaction: ready low after E0+lat-1, high with the result after
    // E0+lat, still held one edge later, then cleared once start drops.
    task automatic runOp(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] expected, input int lat);
        applyStimulus(sgn, a, b);
        repeat (lat) @(negedge clk);
        checkOutput({tag, "_early"}, {63'h0, bus.ready_o}, 64'h0);
        @(negedge clk);
        checkOutput({tag, "_ready"}, {63'h0, bus.ready_o}, 64'h1);
        checkOutput({tag, "_result"}, bus.result_o, expected);
        @(negedge clk);
        checkOutput({tag, "_hold"}, {63'h0, bus.ready_o}, 64'h1);
        bus.start_i = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_drop_ready"}, {63'h0, bus.ready_o}, 64'h0);
        checkOutput({tag, "_drop_result"}, bus.result_o, 64'h0);
    endtask

    initial begin
        int readySeen;
        compared         = 0;
        mismatched       = 0;
        rst              = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'h0;
        bus.opdata2_i    = 32'h0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset_ready", {63'h0, bus.ready_o}, 64'h0);
        checkOutput("reset_result", bus.result_o, 64'h0);
        rst = 1'b0;

        runOp("u7_2",     1'b0, 32'd7,         32'd2,         64'h00000001_00000003, 34);
        runOp("s-7_2",    1'b1, 32'hFFFFFFF9,  32'h00000002,  64'hFFFFFFFF_FFFFFFFD, 34);
        runOp("s7_-2",    1'b1, 32'h00000007,  32'hFFFFFFFE,  64'h00000001_FFFFFFFD, 34);
        runOp("u_byzero", 1'b0, 32'd1234,      32'd0,         64'h0,                 3);
        runOp("s_byzero", 1'b1, 32'hFFFFFF00,  32'd0,         64'h0,                 3);
        runOp("s_minneg", 1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 34);
        runOp("u_max_1",  1'b0, 32'hFFFFFFFF,  32'd1,         64'h00000000_FFFFFFFF, 34);
        runOp("u5_max",   1'b0, 32'd5,         32'hFFFFFFFF,  64'h00000005_00000000, 34);

        // Annul ten cycles into a division; nothing may come out afterwards.
        applyStimulus(1'b0, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        @(negedge clk);
        bus.annul_i = 1'b0;
        readySeen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.ready_o !== 1'b0) readySeen++;
        end
        checkOutput("annul_no_ready", 64'(readySeen), 64'h0);
        runOp("after_annul", 1'b0, 32'd1000, 32'd3, 64'h00000001_0000014D, 34);

        // Reset twenty cycles into ON.
        applyStimulus(1'b0, 32'd50000, 32'd13);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_on_ready", {63'h0, bus.ready_o}, 64'h0);
        checkOutput("rst_on_result", bus.result_o, 64'h0);
        rst = 1'b0;
        bus.start_i = 1'b0;

        // Reset while sitting in END with start still high.
        applyStimulus(1'b0, 32'd9, 32'd4);
        repeat (36) @(negedge clk);
        checkOutput("pre_rst_end_ready", {63'h0, bus.ready_o}, 64'h1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_end_ready", {63'h0, bus.ready_o}, 64'h0);
        checkOutput("rst_end_result", bus.result_o, 64'h0);
        rst = 1'b0;
        bus.start_i = 1'b0;
        @(negedge clk);

        runOp("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
